circuit1_driver: RTL and testbench
==================================

Name: circuit1_driver

Overview:
Handshake front/back end for the three-operand signed datapath. The datapath computes z = a+b (8-bit, combinational) and x = a*c - (a+b) (16-bit, registered one cycle).
The driver accepts operand triples from upstream over valid/ready and holds them stable on the datapath inputs. It waits out the datapath latency, captures z/x, and presents them downstream over valid/ready.
It is the producer of a/b/c and the consumer of z/x.

Parameters:
DATAWIDTH, 8, width of operands and z
XWIDTH, 16, width of x
LATENCY, 1, datapath register stages between operand inputs and x (range 1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream operand triple valid
in_ready  output  1  driver can accept a triple this cycle
in_a  input  DATAWIDTH  signed operand a
in_b  input  DATAWIDTH  signed operand b
in_c  input  DATAWIDTH  signed operand c
dp_a  output  DATAWIDTH  registered operand a to datapath
dp_b  output  DATAWIDTH  registered operand b to datapath
dp_c  output  DATAWIDTH  registered operand c to datapath
dp_z  input  DATAWIDTH  datapath z (combinational from dp_*)
dp_x  input  XWIDTH  datapath x (registered)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_z  output  DATAWIDTH  captured signed z
out_x  output  XWIDTH  captured signed x
out_count  output  16  number of completed output handshakes, wraps 0xFFFF->0

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst. All state updates occur on the rising edge of clk.
- Reset values:
  - state=IDLE
  - dp_a/dp_b/dp_c=0
  - out_z=0, out_x=0
  - out_valid=0
  - out_count=0
  - latency counter=0
  - The datapath shares clk/rst, so its x register also clears.
- States: IDLE, WAIT, FULL.
- in_ready = (state==IDLE) | (state==FULL & out_ready). This is combinational, so out_ready->in_ready is a permitted combinational path.
- Accept is in_valid & in_ready, at edge E0:
  - dp_* <= in_*, cnt <= 0, state <= WAIT.
- WAIT:
  - dp_* are held constant.
  - Each edge: if cnt==LATENCY, then out_z <= dp_z, out_x <= dp_x, state <= FULL. Otherwise cnt <= cnt+1.
  - With LATENCY=1, capture occurs at E2 and out_valid is first high in the cycle after E2. Accept-to-out_valid = LATENCY+1 cycles.
- FULL:
  - out_valid=1; out_z/out_x held until handshake.
  - On out_valid & out_ready: out_count <= out_count+1.
  - Then: if in_valid also high (pass-through accept), dp_* <= in_*, cnt <= 0, state <= WAIT. Otherwise state <= IDLE.
  - out_valid drops the cycle after the handshake in either case.
- out_valid = (state==FULL), driven from a registered state bit.
- in_valid with no accept (WAIT, or FULL without out_ready): the input is ignored. Upstream must hold the triple; the driver never latches it.
- out_ready while not FULL: ignored.
- dp_* change only on accept, so inputs are stable for the whole WAIT window.
- Arithmetic is done by the datapath; the driver does no math. Captured values are passed bit-exact, and sign is carried by two's complement.
- rst asserted in any state, including mid-WAIT or FULL with a result pending: the pending triple/result is discarded, out_valid=0 the next cycle, out_count=0. No handshake completes on a reset edge.
- Throughput: one result per LATENCY+2 cycles with out_ready held high (accept, LATENCY+1 wait edges, overlap accept on the output handshake).

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1. Required: in_ready=1, out_valid=0, dp_*=0, out_count=0. No accept on the reset edges.
- Basic: a=3, b=4, c=5, out_ready=1. Required: out_valid high 2 cycles after accept, out_z=0x07, out_x=0x0008, out_count=1.
- Signed: a=-2, b=1, c=3. Required: out_z=0xFF, out_x=0xFFFB (-5).
- Wrap: a=127, b=1, c=0. Required: out_z=0x80, out_x=0x0080.
- Backpressure: out_ready=0 for 5 cycles after out_valid, second triple offered. Required: out_z/out_x stable, in_ready=0, dp_* unchanged. Then raise out_ready with in_valid=1: handshake and accept occur on the same edge, and the second result appears LATENCY+1 cycles later.
- Reset mid-WAIT: assert rst one cycle after accept. Required: no out_valid ever for that triple, and out_count stays 0.

Source files
------------

// File: rtl/circuit1_driver.sv
// circuit1_driver: valid/ready wrapper around the three-operand signed datapath.
// Accepts an operand triple, holds it on dp_a/dp_b/dp_c while the datapath
// result settles, captures dp_z/dp_x, and offers them downstream.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holds its data stable while valid
// is high and no transfer has happened. in_ready depends combinationally on
// out_ready, so the driver can take a new triple on the same edge that the
// downstream consumer takes the pending result.
module circuit1_driver #(
  parameter int DATAWIDTH = 8,
  parameter int XWIDTH    = 16,
  parameter int LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_a,
  input  logic [DATAWIDTH-1:0] in_b,
  input  logic [DATAWIDTH-1:0] in_c,
  output logic [DATAWIDTH-1:0] dp_a,
  output logic [DATAWIDTH-1:0] dp_b,
  output logic [DATAWIDTH-1:0] dp_c,
  input  logic [DATAWIDTH-1:0] dp_z,
  input  logic [XWIDTH-1:0]    dp_x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_z,
  output logic [XWIDTH-1:0]    out_x,
  output logic [15:0]          out_count
);

  // IDLE: empty. WAIT: triple held on dp_*, counting datapath latency.
  // FULL: result captured and offered downstream.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  // The counter runs 0..LATENCY; LATENCY tops out at 15.
  localparam logic [3:0] LAT_L = 4'(LATENCY);

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [DATAWIDTH-1:0] r_dp_a;
  logic [DATAWIDTH-1:0] r_dp_b;
  logic [DATAWIDTH-1:0] r_dp_c;
  logic [DATAWIDTH-1:0] r_out_z;
  logic [XWIDTH-1:0]    r_out_x;
  logic                 r_out_valid;
  logic [15:0]          r_out_count;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_out_hs;

  // Ready whenever empty, or when the pending result leaves this same edge.
  always_comb begin
    w_in_ready = (r_state == S_IDLE) | ((r_state == S_FULL) & out_ready);
    w_accept   = in_valid & w_in_ready;
    w_out_hs   = r_out_valid & out_ready;
  end

  // Single FSM: accept, wait out the datapath latency, capture, hand off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_dp_c      <= '0;
      r_out_z     <= '0;
      r_out_x     <= '0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dp_a  <= in_a;
            r_dp_b  <= in_b;
            r_dp_c  <= in_c;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == LAT_L) begin
            r_out_z     <= dp_z;
            r_out_x     <= dp_x;
            r_out_valid <= 1'b1;
            r_state     <= S_FULL;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_FULL: begin
          if (w_out_hs) begin
            r_out_count <= r_out_count + 16'd1;
            r_out_valid <= 1'b0;
            if (w_accept) begin
              // Pass-through: the next triple enters on the handoff edge.
              r_dp_a  <= in_a;
              r_dp_b  <= in_b;
              r_dp_c  <= in_c;
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign dp_a      = r_dp_a;
  assign dp_b      = r_dp_b;
  assign dp_c      = r_dp_c;
  assign out_valid = r_out_valid;
  assign out_z     = r_out_z;
  assign out_x     = r_out_x;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_circuit1_driver.sv
// Bench for circuit1_driver: directed cases plus randomized traffic, checked
// against a transaction-level model (accept edge + fixed latency, result from
// plain signed arithmetic, expected results queued in exp_q).
module tb_circuit1_driver;

  localparam int DW  = 8;
  localparam int XW  = 16;
  localparam int LAT = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0, in_b = '0, in_c = '0;
  logic [DW-1:0] dp_a, dp_b, dp_c, dp_z;
  logic [XW-1:0] dp_x;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_z;
  logic [XW-1:0] out_x;
  logic [15:0]   out_count;

  circuit1_driver #(.DATAWIDTH(DW), .XWIDTH(XW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
    .dp_z(dp_z), .dp_x(dp_x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_x(out_x), .out_count(out_count)
  );

  // ---------------- datapath stand-in ----------------
  logic [XW-1:0] x_next;
  logic [XW-1:0] x_pipe [LAT];
  assign dp_z = dp_a + dp_b;
  assign dp_x = x_pipe[LAT-1];

  always_comb begin
    int pa, pc, pz;
    pa = int'($signed(dp_a));
    pc = int'($signed(dp_c));
    pz = int'($signed(dp_z));
    x_next = 16'(pa * pc - pz);
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) x_pipe[i] <= '0;
    end else begin
      x_pipe[0] <= x_next;
      for (int i = 1; i < LAT; i++) x_pipe[i] <= x_pipe[i-1];
    end
  end

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {z, x} from the arithmetic definition.
  function automatic logic [23:0] ref_calc(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
    int sa, sb, sc, xi;
    logic [7:0] z8;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sc = int'($signed(c));
    z8 = 8'(sa + sb);
    xi = sa * sc - int'($signed(z8));
    return {z8, xi[15:0]};
  endfunction

  // ---------------- reference model / scoreboard ----------------
  // A held triple becomes visible as a result LAT+1 edges after its accept edge.
  int          n_edges     = 0;
  bit          m_busy      = 1'b0;
  int          m_full_edge = 0;
  logic [15:0] m_count     = '0;
  logic [7:0]  m_a = '0, m_b = '0, m_c = '0;
  bit          m_acc_last  = 1'b0;
  logic [23:0] exp_q[$];
  bit          mon_en      = 1'b0;

  always @(posedge clk) begin
    bit full, rdy;
    full = m_busy && (n_edges >= m_full_edge);
    rdy  = !m_busy || (full && out_ready);
    m_acc_last = 1'b0;
    if (rst) begin
      m_busy  = 1'b0;
      m_count = '0;
      m_a = '0; m_b = '0; m_c = '0;
      exp_q.delete();
    end else begin
      if (full && out_ready) begin
        m_count = m_count + 16'd1;
        m_busy  = 1'b0;
        void'(exp_q.pop_front());
      end
      if (in_valid && rdy) begin
        m_busy      = 1'b1;
        m_full_edge = n_edges + 1 + LAT + 1;
        m_a = in_a; m_b = in_b; m_c = in_c;
        exp_q.push_back(ref_calc(in_a, in_b, in_c));
        m_acc_last = 1'b1;
      end
    end
    n_edges++;
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    bit full;
    if (mon_en) begin
      full = m_busy && (n_edges >= m_full_edge);
      check("in_ready",  32'(in_ready),  32'(!m_busy || (full && out_ready)));
      check("out_valid", 32'(out_valid), 32'(full));
      check("dp_a",      32'(dp_a),      32'(m_a));
      check("dp_b",      32'(dp_b),      32'(m_b));
      check("dp_c",      32'(dp_c),      32'(m_c));
      check("out_count", 32'(out_count), 32'(m_count));
      if (full && exp_q.size() > 0) begin
        check("out_z", 32'(out_z), 32'(exp_q[0][23:16]));
        check("out_x", 32'(out_x), 32'(exp_q[0][15:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a triple for one edge; caller ensures the driver is ready.
  task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_c = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count mid-cycle samples until out_valid, bounded.
  task automatic wait_valid(output int k);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] ez, input logic [15:0] ex);
    int k;
    out_ready = 1'b1;
    offer(a, b, c);
    wait_valid(k);
    check({tag, "_latency"}, 32'(k), 32'(LAT + 1));
    check({tag, "_z"}, 32'(out_z), 32'(ez));
    check({tag, "_x"}, 32'(out_x), 32'(ex));
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;

    // Reset held two edges with a triple offered: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_c = 8'h33;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dp_a",      32'(dp_a),      32'd0);
    check("rst_dp_b",      32'(dp_b),      32'd0);
    check("rst_dp_c",      32'(dp_c),      32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_z",     32'(out_z),     32'd0);
    check("rst_out_x",     32'(out_x),     32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    mon_en = 1'b1;

    directed("basic",  8'd3,   8'd4, 8'd5, 8'h07, 16'h0008);
    check("basic_count", 32'(out_count), 32'd1);
    directed("signed", 8'hFE,  8'd1, 8'd3, 8'hFF, 16'hFFFB);
    directed("wrap",   8'd127, 8'd1, 8'd0, 8'h80, 16'h0080);
    check("wrap_count", 32'(out_count), 32'd3);

    // Backpressure with a second triple waiting.
    out_ready = 1'b0;
    offer(8'd10, 8'd20, 8'd3);
    wait_valid(k);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd6; in_c = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_z",        32'(out_z),    32'h1E);
      check("bp_x",        32'(out_x),    32'h0000);
      check("bp_dp_a",     32'(dp_a),     32'd10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_dp_a_new", 32'(dp_a), 32'd5);
    wait_valid(k);
    check("bp2_latency", 32'(k), 32'(LAT + 1));
    check("bp2_z", 32'(out_z), 32'h0B);
    check("bp2_x", 32'(out_x), 32'h0018);
    @(posedge clk); #1;

    // Reset one edge after an accept: the triple never produces a result.
    out_ready = 1'b1;
    offer(8'd1, 8'd2, 8'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rstwait_valid", 32'(out_valid), 32'd0);
      check("rstwait_count", 32'(out_count), 32'd0);
      @(posedge clk); #1;
    end

    // Randomized traffic; an unaccepted triple is held until taken.
    for (int i = 0; i < 800; i++) begin
      if (!(in_valid && !m_acc_last)) begin
        in_valid = ($urandom_range(0, 99) < 60);
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        in_c = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 99) < 70);
      rst = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
